// File: rtl/risc_pkg.sv
// Shared processor definitions: skid-buffer occupancy encodings and the default datapath width.
package risc_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry skid register with valid/ready handshake; output always driven from main.
// in_ready is registered and only deasserts when both entries are full.
module pipe_skid_reg
  import risc_pkg::*;
#(
  parameter int W = DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i
);

  occ_e         state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q, rdy_d;
  logic         in_xfer, out_xfer;

  assign in_xfer  = valid_i & rdy_q;
  assign out_xfer = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = data_i;
        end else if (in_xfer) begin
          skid_d  = data_i;
          state_d = ST_TWO;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // rdy_q is low here, so only the skid->main move can happen
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    rdy_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign ready_o = rdy_q;
  assign valid_o = (state_q != ST_EMPTY);
  assign data_o  = main_q;

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// NUM_IN:1 operand select feeding a registered 2-entry skid stage.
// MUX_SEL_RANGE_CHECK_EN: out-of-range sel yields data 0 with sel_err=1; otherwise it selects input 0.
module mux_n_to_1_pipe
  import risc_pkg::*;
#(
  parameter  int WIDTH  = DATA_W,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH*NUM_IN-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;
  logic [WIDTH:0]   skid_out;

  always_comb begin
    sel_word = in_bus[0 +: WIDTH];
    for (int k = 1; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) sel_word = in_bus[k*WIDTH +: WIDTH];
    end
`ifdef MUX_SEL_RANGE_CHECK_EN
    // extra bit keeps the bound from wrapping to 0 when NUM_IN is a power of 2
    sel_bad = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
    if (sel_bad) sel_word = '0;
`else
    sel_bad = 1'b0;
`endif
  end

  pipe_skid_reg #(.W(WIDTH + 1)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  ({sel_bad, sel_word}),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_o  (skid_out),
    .valid_o (out_valid),
    .ready_i (out_ready)
  );

  assign out_data = skid_out[WIDTH-1:0];
  assign sel_err  = skid_out[WIDTH];

endmodule
